// File: rtl/perm8_pkg.sv
// Shared definitions for the perm8 inverse engine: FSM states, inverse nibble
// map and a forward-map helper for building round-trip reference words.
package perm8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLES = 8;

    // INV_SRC[k] is the input nibble that lands in output nibble k after one inverse round.
    localparam int unsigned INV_SRC [NIBBLES] = '{4, 1, 0, 5, 6, 3, 2, 7};

    function automatic logic [31:0] perm8_fwd_word(input logic [31:0] x);
        return {x[31:28], x[19:16], x[15:12], x[3:0],
                x[23:20], x[27:24], x[7:4],   x[11:8]};
    endfunction

endpackage

// File: rtl/perm8_inv.sv
// One combinational round of the inverse 32-bit nibble permutation.
module perm8_inv (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    import perm8_pkg::*;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        localparam int unsigned SRC = INV_SRC[gi];
        assign word_o[4*gi +: 4] = word_i[4*SRC +: 4];
    end

endmodule

// File: rtl/perm8_inv_engine.sv
// Applies the inverse nibble permutation N times to one word, one round per
// clock, between an input and an output valid/ready handshake.
module perm8_inv_engine #(
    parameter int RND_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      D_IN,
    input  logic [RND_W-1:0] N_ROUNDS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      D_OUT,
    output logic             BUSY
);
    import perm8_pkg::*;

    state_t           state_q;
    logic [31:0]      work_q;
    logic [31:0]      work_d;
    logic [RND_W-1:0] cnt_q;
    logic [RND_W-1:0] cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    perm8_inv u_inv (
        .word_i (work_q),
        .word_o (work_d)
    );

    assign cnt_d = cnt_q - RND_W'(1);

    // Handshake outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_ready_q && IN_VALID) begin
                        work_q     <= D_IN;
                        cnt_q      <= N_ROUNDS;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (N_ROUNDS == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_d;
                    if (cnt_q == RND_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign D_OUT     = work_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_perm8_inv_engine.sv
// Directed and randomized checks of perm8_inv_engine against a queue-based scoreboard.
module tb_perm8_inv_engine;
    import perm8_pkg::*;

    localparam int RND_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [31:0]      D_IN = '0;
    logic [RND_W-1:0] N_ROUNDS = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [31:0]      D_OUT;
    logic             BUSY;

    int          n_assert = 0;
    int          n_fail = 0;
    int          n_pushed = 0;
    int          n_out = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;
    bit          rnd_ready = 1'b0;

    logic [31:0] dir_exp [4] = '{32'h72365014, 32'h70523416, 32'h76543210, 32'h76543210};
    int          dir_n   [4] = '{1, 2, 4, 0};

    perm8_inv_engine #(.RND_W(RND_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .D_IN      (D_IN),
        .N_ROUNDS  (N_ROUNDS),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .D_OUT     (D_OUT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: one inverse round written out nibble by nibble.
    function automatic logic [31:0] model_inv(input logic [31:0] x, input int n);
        logic [31:0] z;
        z = x;
        for (int i = 0; i < n; i++)
            z = {z[31:28], z[11:8], z[15:12], z[27:24], z[23:20], z[3:0], z[7:4], z[19:16]};
        return z;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int n, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        D_IN     = d;
        N_ROUNDS = RND_W'(n);
        IN_VALID = 1'b1;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge CLK);
            if (IN_READY && RST_N) ok = 1'b1;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        chk("send_accept", 32'(ok), 1);
        if (ok) begin
            sb.push_back(exp);
            n_pushed++;
        end
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while ((sb.size() != 0 || BUSY) && c < 2000) begin
            tick();
            c++;
        end
        chk({tag, "_drain"}, 32'(sb.size() == 0 && !BUSY), 1);
    endtask

    // Output side of the scoreboard: a handshake completes at the next rising edge.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_output: observed D_OUT=%h expected no output", D_OUT);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("sb_d_out", D_OUT, mon_exp);
                n_out++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] orig;
        logic [31:0] d;
        int          n;
        bit          seen;

        // Reset and release
        RST_N     = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(IN_READY), 0);
        chk("rst_out_valid", 32'(OUT_VALID), 0);
        chk("rst_d_out", D_OUT, 32'h0);
        chk("rst_busy", 32'(BUSY), 0);
        RST_N = 1'b1;
        tick();
        chk("rel_in_ready", 32'(IN_READY), 1);
        chk("rel_out_valid", 32'(OUT_VALID), 0);
        chk("rel_busy", 32'(BUSY), 0);

        // Single round undoes the forward stage; BUSY spans two cycles
        send(32'h74305612, 1, model_inv(32'h74305612, 1));
        chk("n1_busy0", 32'(BUSY), 1);
        chk("n1_valid0", 32'(OUT_VALID), 0);
        tick();
        chk("n1_valid1", 32'(OUT_VALID), 1);
        chk("n1_d_out", D_OUT, 32'h76543210);
        chk("n1_busy1", 32'(BUSY), 1);
        tick();
        chk("n1_busy2", 32'(BUSY), 0);
        chk("n1_valid2", 32'(OUT_VALID), 0);

        // Round counts 1, 2, 4 and 0 with latency check
        for (int i = 0; i < 4; i++) begin
            send(32'h76543210, dir_n[i], model_inv(32'h76543210, dir_n[i]));
            for (int k = 0; k < dir_n[i]; k++) begin
                chk("lat_low", 32'(OUT_VALID), 0);
                tick();
            end
            chk("lat_high", 32'(OUT_VALID), 1);
            chk("lat_d_out", D_OUT, dir_exp[i]);
            drain("dir");
        end

        // Back-pressure: DONE held, input pulses ignored
        OUT_READY = 1'b0;
        send(32'h76543210, 2, model_inv(32'h76543210, 2));
        for (int c = 0; c < 20 && !OUT_VALID; c++) tick();
        chk("bp_valid_rise", 32'(OUT_VALID), 1);
        for (int k = 0; k < 10; k++) begin
            IN_VALID = (k % 2 == 0);
            D_IN     = $urandom;
            N_ROUNDS = RND_W'($urandom_range(0, 15));
            tick();
            chk("bp_d_out", D_OUT, 32'h70523416);
            chk("bp_valid", 32'(OUT_VALID), 1);
            chk("bp_in_ready", 32'(IN_READY), 0);
        end
        IN_VALID = 1'b0;
        // New word offered on the same edge the result is taken: accepted one cycle later
        OUT_READY = 1'b1;
        send(32'h74305612, 1, model_inv(32'h74305612, 1));
        chk("ovl_valid0", 32'(OUT_VALID), 0);
        tick();
        chk("ovl_valid1", 32'(OUT_VALID), 1);
        chk("ovl_d_out", D_OUT, 32'h76543210);
        drain("bp");

        // Reset in the middle of a 15-round word
        send(32'h76543210, 15, model_inv(32'h76543210, 15));
        repeat (7) tick();
        chk("mid_busy", 32'(BUSY), 1);
        RST_N = 1'b0;
        tick();
        n_pushed -= sb.size();
        sb.delete();
        chk("mid_rst_valid", 32'(OUT_VALID), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_in_ready", 32'(IN_READY), 0);
        chk("mid_rst_d_out", D_OUT, 32'h0);
        RST_N = 1'b1;
        tick();
        chk("mid_rel_in_ready", 32'(IN_READY), 1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (OUT_VALID) seen = 1'b1;
        end
        chk("mid_discard", 32'(seen), 0);
        send(32'h74305612, 1, model_inv(32'h74305612, 1));
        drain("post_rst");

        // Random stream: words built with the forward map, so the expected output is the original
        rnd_ready = 1'b1;
        fork
            begin
                while (rnd_ready) begin
                    @(posedge CLK);
                    #1;
                    if (rnd_ready) OUT_READY = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            orig = $urandom;
            n    = int'($urandom_range(0, 15));
            d    = orig;
            for (int k = 0; k < n; k++) d = perm8_fwd_word(d);
            send(d, n, orig);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain("rnd");
        rnd_ready = 1'b0;
        tick();
        OUT_READY = 1'b1;
        drain("final");
        chk("word_count", 32'(n_out), 32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
